// File: rtl/traffic_pkg.sv
// Shared types and default phase durations for the intersection sequencer.
package traffic_pkg;

    typedef enum logic [1:0] {
        RED    = 2'b00,
        YELLOW = 2'b01,
        GREEN  = 2'b10
    } light_t;

    typedef enum logic [2:0] {
        HG  = 3'd0,
        HY  = 3'd1,
        AR1 = 3'd2,
        FG  = 3'd3,
        FY  = 3'd4,
        AR2 = 3'd5,
        PW  = 3'd6
    } phase_t;

    // Default phase durations, in timer ticks.
    localparam logic [7:0] DEF_HG_MIN_T = 8'd20;
    localparam logic [7:0] DEF_FG_T     = 8'd10;
    localparam logic [7:0] DEF_YEL_T    = 8'd3;
    localparam logic [7:0] DEF_RED_T    = 8'd1;
    localparam logic [7:0] DEF_WALK_T   = 8'd8;
    localparam int         DEF_TICK_DIV = 1000;

endpackage

// File: rtl/down_counter.sv
// 8-bit loadable down-counter used to time each phase; holds at zero.
module down_counter (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_load,
    input  logic [7:0] i_value,
    input  logic       i_decr,
    output logic       o_timeup
);

    logic [7:0] r_count;

    // Load has priority over decrement; the count saturates at zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= 8'd0;
        end else if (i_load) begin
            r_count <= i_value;
        end else if (i_decr && (r_count != 8'd0)) begin
            r_count <= r_count - 8'd1;
        end
    end

    assign o_timeup = (r_count == 8'd0);

endmodule

// File: rtl/traffic_phase_sequencer_tick_gen.sv
// Free-running prescaler: one-cycle tick every DIV clock cycles.
module tick_gen #(
    parameter int DIV = 1000
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int W = (DIV > 1) ? $clog2(DIV) : 1;

    logic [W-1:0] r_cnt;
    logic         w_wrap;

    assign w_wrap = (r_cnt == W'(DIV - 1));
    assign tick   = w_wrap;

    // Modulo-DIV count; never resynchronised except by reset.
    always_ff @(posedge clk) begin
        if (reset || w_wrap) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + W'(1);
        end
    end

endmodule

// File: rtl/traffic_phase_sequencer.sv
// Moore sequencer for a highway/farm-road intersection with a walk phase.
// Phase timing comes from an external down-counter driven via tmr_*.
module traffic_phase_sequencer
    import traffic_pkg::*;
#(
    parameter int         TICK_DIV = DEF_TICK_DIV,
    parameter logic [7:0] HG_MIN_T = DEF_HG_MIN_T,
    parameter logic [7:0] FG_T     = DEF_FG_T,
    parameter logic [7:0] YEL_T    = DEF_YEL_T,
    parameter logic [7:0] RED_T    = DEF_RED_T,
    parameter logic [7:0] WALK_T   = DEF_WALK_T
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       farm_car,
    input  logic       ped_btn,
    input  logic       tmr_timeup,
    output logic       tmr_load,
    output logic [7:0] tmr_value,
    output logic       tmr_decr,
    output logic [1:0] hwy_light,
    output logic [1:0] farm_light,
    output logic       walk,
    output logic [2:0] phase
);

    phase_t     r_state;
    phase_t     w_state_nxt;
    logic       r_first;
    logic       w_first_nxt;
    logic       r_farm_req;
    logic       r_ped_pend;
    logic       w_tick;
    logic [7:0] w_dur;

    function automatic logic [7:0] phase_dur(input phase_t s);
        case (s)
            HG:       phase_dur = HG_MIN_T;
            HY, FY:   phase_dur = YEL_T;
            AR1, AR2: phase_dur = RED_T;
            FG:       phase_dur = FG_T;
            PW:       phase_dur = WALK_T;
            default:  phase_dur = RED_T;
        endcase
    endfunction

    tick_gen #(.DIV(TICK_DIV)) u_tick (
        .clk   (clk),
        .reset (reset),
        .tick  (w_tick)
    );

    // State register and entry-cycle flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= AR2;
            r_first <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_first <= w_first_nxt;
        end
    end

    // Request latches; the clear on the serving phase's entry cycle wins over a new set.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_farm_req <= 1'b0;
            r_ped_pend <= 1'b0;
        end else begin
            if (r_state == FG && r_first) begin
                r_farm_req <= 1'b0;
            end else if (farm_car) begin
                r_farm_req <= 1'b1;
            end
            if (r_state == PW && r_first) begin
                r_ped_pend <= 1'b0;
            end else if (ped_btn && r_state != PW) begin
                r_ped_pend <= 1'b1;
            end
        end
    end

    // Next state: timeup is only trusted once the entry-cycle load has landed.
    always_comb begin
        w_state_nxt = r_state;
        w_first_nxt = 1'b0;
        if (!r_first && tmr_timeup) begin
            w_first_nxt = 1'b1;
            case (r_state)
                HG: begin
                    if (r_farm_req || r_ped_pend) begin
                        w_state_nxt = HY;
                    end else begin
                        w_first_nxt = 1'b0;
                    end
                end
                HY:      w_state_nxt = AR1;
                AR1:     w_state_nxt = r_farm_req ? FG : PW;
                FG:      w_state_nxt = FY;
                FY:      w_state_nxt = AR2;
                AR2:     w_state_nxt = r_ped_pend ? PW : HG;
                PW:      w_state_nxt = HG;
                default: w_state_nxt = AR2;
            endcase
        end
    end

    // Moore outputs; reset forces every lamp to RED and silences the timer strobes.
    always_comb begin
        w_dur      = phase_dur(r_state);
        tmr_value  = w_dur;
        tmr_load   = 1'b0;
        tmr_decr   = 1'b0;
        hwy_light  = RED;
        farm_light = RED;
        walk       = 1'b0;
        phase      = r_state;
        if (!reset) begin
            tmr_load = r_first;
            tmr_decr = !r_first && w_tick;
            case (r_state)
                HG:      hwy_light  = GREEN;
                HY:      hwy_light  = YELLOW;
                FG:      farm_light = GREEN;
                FY:      farm_light = YELLOW;
                PW:      walk       = 1'b1;
                default: ;
            endcase
        end
    end

endmodule
